uart_core: RTL and testbench

//  Full-duplex parametrised UART: independent TX and RX engines sharing one

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_baud_gen.sv | 41 ++++
 rtl/uart_core.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART core. Contains the TX
//               and RX state encodings, the parity-select constants and the
//               parity helper used by both engines.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Widest frame payload the core supports. The parity helper works on
  // zero-extended data of this width; zero padding does not change the XOR.
  localparam int c_MAX_DATA_BITS = 9;

  // Parity select values, used as the 'odd' argument of parity_bit().
  localparam logic c_PARITY_EVEN = 1'b0;
  localparam logic c_PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Parity bit to transmit (or expect) for a data word.
  function automatic logic parity_bit(input logic [c_MAX_DATA_BITS-1:0] data,
                                      input logic                       odd);
    return (^data) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Free-running oversample tick generator. The counter runs
//               0..baud_div and produces a one-cycle tick on the wrap cycle,
//               so the tick period is baud_div+1 clocks.
// Ports       : clk      - system clock
//               rst      - asynchronous reset, active low
//               baud_div - clocks per tick minus one
//               tick     - one-cycle oversample strobe
// Revision    : 1.0  initial release
// ============================================================================
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] r_count;
  logic                 w_wrap;

  // '>=' rather than '==' so that lowering baud_div below the current count
  // wraps on the next cycle instead of running all the way round.
  assign w_wrap = (r_count >= baud_div);
  assign tick   = w_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_core
// Description : Full-duplex UART. Independent TX and RX engines share one
//               oversample tick; valid/ready handshakes on both bus sides and
//               per-frame parity/framing flags plus a sticky overrun flag.
// Ports       : clk, rst (async, active low)
//               baud_div               - clocks per oversample tick minus one
//               tx_data/tx_valid/tx_ready - transmit handshake
//               tx                     - serial output, idle high
//               rx                     - serial input, asynchronous
//               rx_data/rx_valid/rx_ready - receive handshake
//               rx_parity_err, rx_frame_err - status of the frame in rx_data
//               rx_overrun             - sticky, a frame was dropped
// Revision    : 1.0  initial release
// ============================================================================
module uart_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int              c_TW             = $clog2(OVERSAMPLE + 1);
  localparam int              c_BW             = $clog2(c_MAX_DATA_BITS + 1);
  localparam logic [c_TW-1:0] c_TICK_LAST      = c_TW'(OVERSAMPLE - 1);
  localparam logic [c_TW-1:0] c_TICK_FULL      = c_TW'(OVERSAMPLE);
  localparam logic [c_TW-1:0] c_TICK_HALF_LAST = c_TW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_BW-1:0] c_DATA_LAST      = c_BW'(DATA_BITS - 1);
  localparam logic [c_BW-1:0] c_STOP_LAST      = c_BW'(STOP_BITS - 1);
  localparam logic            c_PAR_SEL        = (PARITY_ODD != 0) ? c_PARITY_ODD : c_PARITY_EVEN;
  localparam logic            c_PAR_ON         = (PARITY_EN != 0);

  logic w_tick;

  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .baud_div (baud_div),
    .tick     (w_tick)
  );

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  tx_state_t                  r_tx_state;
  tx_state_t                  w_tx_state_nx;
  logic [DATA_BITS-1:0]       r_tx_shift;
  logic                       r_tx_par;
  logic [c_TW-1:0]            r_tx_ticks;
  logic [c_BW-1:0]            r_tx_bits;
  logic                       w_tx_accept;
  logic                       w_tx_bit_end;
  logic                       w_tx_line;
  logic                       w_tx_ready;
  logic [c_MAX_DATA_BITS-1:0] w_tx_data_ext;

  always_comb begin
    w_tx_data_ext                = '0;
    w_tx_data_ext[DATA_BITS-1:0] = tx_data;
  end

  assign w_tx_accept = tx_valid && (r_tx_state == TX_IDLE);

  // START counts one extra tick: the first tick after accept only opens the
  // start bit (tx goes low), the following OVERSAMPLE ticks time its length.
  assign w_tx_bit_end = w_tick &&
                        ((r_tx_state == TX_START) ? (r_tx_ticks == c_TICK_FULL)
                                                  : (r_tx_ticks == c_TICK_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_state_nx;
    end
  end

  always_comb begin
    w_tx_state_nx = r_tx_state;
    case (r_tx_state)
      TX_IDLE:   if (w_tx_accept)  w_tx_state_nx = TX_START;
      TX_START:  if (w_tx_bit_end) w_tx_state_nx = TX_DATA;
      TX_DATA:   if (w_tx_bit_end && (r_tx_bits == c_DATA_LAST))
                   w_tx_state_nx = c_PAR_ON ? TX_PARITY : TX_STOP;
      TX_PARITY: if (w_tx_bit_end) w_tx_state_nx = TX_STOP;
      TX_STOP:   if (w_tx_bit_end && (r_tx_bits == c_STOP_LAST))
                   w_tx_state_nx = TX_IDLE;
      default:   w_tx_state_nx = TX_IDLE;
    endcase
  end

  always_comb begin
    w_tx_line  = 1'b1;
    w_tx_ready = 1'b0;
    case (r_tx_state)
      TX_IDLE:   w_tx_ready = 1'b1;
      TX_START:  w_tx_line  = (r_tx_ticks == '0);
      TX_DATA:   w_tx_line  = r_tx_shift[0];
      TX_PARITY: w_tx_line  = r_tx_par;
      default:   w_tx_line  = 1'b1;
    endcase
  end

  assign tx       = w_tx_line;
  assign tx_ready = w_tx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_ticks <= '0;
      r_tx_bits  <= '0;
    end else if (r_tx_state == TX_IDLE) begin
      r_tx_ticks <= '0;
      r_tx_bits  <= '0;
      if (w_tx_accept) begin
        r_tx_shift <= tx_data;
        r_tx_par   <= parity_bit(w_tx_data_ext, c_PAR_SEL);
      end
    end else if (w_tick) begin
      if (w_tx_bit_end) begin
        r_tx_ticks <= '0;
        if (r_tx_state == TX_DATA) begin
          r_tx_shift <= r_tx_shift >> 1;
        end
        // r_tx_bits indexes data bits in DATA and stop bits in STOP; it is
        // cleared on every other bit boundary so each phase starts at zero.
        if (((r_tx_state == TX_DATA) && (r_tx_bits != c_DATA_LAST)) ||
            (r_tx_state == TX_STOP)) begin
          r_tx_bits <= r_tx_bits + 1'b1;
        end else begin
          r_tx_bits <= '0;
        end
      end else begin
        r_tx_ticks <= r_tx_ticks + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  rx_state_t                  r_rx_state;
  rx_state_t                  w_rx_state_nx;
  logic                       r_rx_meta;
  logic                       r_rx_sync;
  logic                       r_rx_prev;
  logic [DATA_BITS-1:0]       r_rx_shift;
  logic                       r_rx_par;
  logic [c_TW-1:0]            r_rx_ticks;
  logic [c_BW-1:0]            r_rx_bits;
  logic [DATA_BITS-1:0]       r_rx_data;
  logic                       r_rx_valid;
  logic                       r_rx_parity_err;
  logic                       r_rx_frame_err;
  logic                       r_rx_overrun;
  logic                       w_rx_fall;
  logic                       w_rx_sample;
  logic                       w_rx_data_sample;
  logic                       w_rx_par_sample;
  logic                       w_rx_stop_sample;
  logic                       w_rx_load;
  logic                       w_rx_handshake;
  logic [c_MAX_DATA_BITS-1:0] w_rx_shift_ext;

  always_comb begin
    w_rx_shift_ext                = '0;
    w_rx_shift_ext[DATA_BITS-1:0] = r_rx_shift;
  end

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  // All reset to the idle-high line level so release never looks like a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_rx_fall = r_rx_prev && !r_rx_sync;

  // Start bit is checked half a bit after the edge; every later sample lands
  // a full bit after the previous one, i.e. mid-bit.
  assign w_rx_sample = w_tick &&
                       ((r_rx_state == RX_START) ? (r_rx_ticks == c_TICK_HALF_LAST)
                                                 : (r_rx_ticks == c_TICK_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_state <= w_rx_state_nx;
    end
  end

  always_comb begin
    w_rx_state_nx = r_rx_state;
    case (r_rx_state)
      RX_IDLE:   if (w_rx_fall)   w_rx_state_nx = RX_START;
      RX_START:  if (w_rx_sample) w_rx_state_nx = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_rx_sample && (r_rx_bits == c_DATA_LAST))
                   w_rx_state_nx = c_PAR_ON ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rx_sample) w_rx_state_nx = RX_STOP;
      RX_STOP:   if (w_rx_sample) w_rx_state_nx = RX_IDLE;
      default:   w_rx_state_nx = RX_IDLE;
    endcase
  end

  always_comb begin
    w_rx_data_sample = 1'b0;
    w_rx_par_sample  = 1'b0;
    w_rx_stop_sample = 1'b0;
    case (r_rx_state)
      RX_DATA:   w_rx_data_sample = w_rx_sample;
      RX_PARITY: w_rx_par_sample  = w_rx_sample;
      RX_STOP:   w_rx_stop_sample = w_rx_sample;
      default:   w_rx_data_sample = 1'b0;
    endcase
  end

  assign w_rx_handshake = r_rx_valid && rx_ready;
  // A finished frame is delivered if the output slot is empty or being
  // emptied this very cycle; otherwise it is dropped.
  assign w_rx_load      = w_rx_stop_sample && (!r_rx_valid || rx_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
      r_rx_ticks <= '0;
      r_rx_bits  <= '0;
    end else if (r_rx_state == RX_IDLE) begin
      r_rx_ticks <= '0;
      r_rx_bits  <= '0;
    end else if (w_tick) begin
      if (w_rx_sample) begin
        r_rx_ticks <= '0;
        if (w_rx_data_sample) begin
          // LSB arrives first, so shift in from the top.
          r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
          r_rx_bits  <= (r_rx_bits == c_DATA_LAST) ? '0 : r_rx_bits + 1'b1;
        end
        if (w_rx_par_sample) begin
          r_rx_par <= r_rx_sync;
        end
      end else begin
        r_rx_ticks <= r_rx_ticks + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_data       <= '0;
      r_rx_valid      <= 1'b0;
      r_rx_parity_err <= 1'b0;
      r_rx_frame_err  <= 1'b0;
      r_rx_overrun    <= 1'b0;
    end else begin
      if (w_rx_load) begin
        r_rx_data       <= r_rx_shift;
        r_rx_valid      <= 1'b1;
        r_rx_parity_err <= c_PAR_ON && (r_rx_par != parity_bit(w_rx_shift_ext, c_PAR_SEL));
        r_rx_frame_err  <= !r_rx_sync;
      end else if (w_rx_handshake) begin
        r_rx_valid <= 1'b0;
      end

      if (w_rx_stop_sample && !w_rx_load) begin
        r_rx_overrun <= 1'b1;
      end else if (w_rx_handshake) begin
        r_rx_overrun <= 1'b0;
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_parity_err = r_rx_parity_err;
  assign rx_frame_err  = r_rx_frame_err;
  assign rx_overrun    = r_rx_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_core
// Description : Directed self-checking bench for uart_core. Instance A runs
//               8N1 for exact TX waveform timing; instance B runs 8O1 with its
//               tx looped to rx, or rx driven by a hand-built frame injector.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] baud_div;

  logic [7:0]  a_tx_data;
  logic        a_tx_valid;
  logic        a_tx_ready;
  logic        a_tx;
  logic [7:0]  a_rx_data;
  logic        a_rx_valid;
  logic        a_rx_perr;
  logic        a_rx_ferr;
  logic        a_rx_ovr;

  logic [7:0]  b_tx_data;
  logic        b_tx_valid;
  logic        b_tx_ready;
  logic        b_tx;
  logic        b_rx;
  logic [7:0]  b_rx_data;
  logic        b_rx_valid;
  logic        b_rx_ready;
  logic        b_rx_perr;
  logic        b_rx_ferr;
  logic        b_rx_ovr;

  logic        inj_en;
  logic        inj_line;

  int          errors = 0;
  int          checks = 0;

  assign b_rx = inj_en ? inj_line : b_tx;

  always #5 clk = ~clk;

  uart_core #(
    .DATA_BITS(8), .OVERSAMPLE(16), .DIV_WIDTH(16),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .baud_div(baud_div),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx(a_tx),
    .rx(1'b1), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(1'b1),
    .rx_parity_err(a_rx_perr), .rx_frame_err(a_rx_ferr), .rx_overrun(a_rx_ovr)
  );

  uart_core #(
    .DATA_BITS(8), .OVERSAMPLE(16), .DIV_WIDTH(16),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .baud_div(baud_div),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx(b_tx),
    .rx(b_rx), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .rx_parity_err(b_rx_perr), .rx_frame_err(b_rx_ferr), .rx_overrun(b_rx_ovr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand one word to B's transmitter once it is idle (bounded wait).
  task automatic b_send(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (b_tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("b_tx_ready_wait", b_tx_ready, 1);
    b_tx_data  = d;
    b_tx_valid = 1'b1;
    @(negedge clk);
    b_tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int max);
    int n;
    n = 0;
    while (b_rx_valid !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("b_rx_valid_wait", b_rx_valid, 1);
  endtask

  task automatic ack_rx();
    @(negedge clk);
    b_rx_ready = 1'b1;
    @(negedge clk);
    b_rx_ready = 1'b0;
  endtask

  // Drive one 8O1 frame onto B's rx; bit_clk clocks per bit.
  task automatic inject(input logic [7:0] d, input logic flip_par,
                        input logic stop_low, input int bit_clk);
    logic p;
    p = (^d) ^ 1'b1 ^ flip_par;
    @(negedge clk);
    inj_line = 1'b0;
    repeat (bit_clk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      inj_line = d[i];
      repeat (bit_clk) @(negedge clk);
    end
    inj_line = p;
    repeat (bit_clk) @(negedge clk);
    inj_line = ~stop_low;
    repeat (bit_clk) @(negedge clk);
    inj_line = 1'b1;
    repeat (2 * bit_clk) @(negedge clk);
  endtask

  initial begin
    logic [9:0] exp_bits;
    int         n;

    baud_div   = 16'd3;
    a_tx_data  = 8'h00;
    a_tx_valid = 1'b0;
    b_tx_data  = 8'h00;
    b_tx_valid = 1'b0;
    b_rx_ready = 1'b0;
    inj_en     = 1'b0;
    inj_line   = 1'b1;
    rst        = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_a_tx",       a_tx,       1);
    check("rst_a_tx_ready", a_tx_ready, 1);
    check("rst_b_tx",       b_tx,       1);
    check("rst_b_tx_ready", b_tx_ready, 1);
    check("rst_b_rx_valid", b_rx_valid, 0);
    check("rst_b_rx_data",  b_rx_data,  0);
    check("rst_b_perr",     b_rx_perr,  0);
    check("rst_b_ferr",     b_rx_ferr,  0);
    check("rst_b_ovr",      b_rx_ovr,   0);
    rst = 1'b1;

    // ---------------- A: 8N1 waveform of 8'hA5, 64 clk/bit ----------------
    repeat (2) @(negedge clk);
    a_tx_data  = 8'hA5;
    a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    check("a_ready_drop", a_tx_ready, 0);
    n = 0;
    while (a_tx !== 1'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("a_start_delay_ok", (n >= 1 && n <= 4), 1);
    exp_bits = {1'b1, 8'hA5, 1'b0};   // stop, data (LSB at bit 1), start
    for (int off = 1; off <= 640; off++) begin
      @(negedge clk);
      if (off == 63)        check("a_start_last_low", a_tx, 0);
      if (off == 64)        check("a_bit0_edge",      a_tx, 1);
      if (off % 64 == 32)   check($sformatf("a_bit%0d", off / 64), a_tx, exp_bits[off / 64]);
      if (off == 639)       check("a_ready_before",   a_tx_ready, 0);
      if (off == 640)       check("a_ready_after",    a_tx_ready, 1);
    end

    // ---------------- B: loopback 8O1, all byte values ----------------
    baud_div = 16'd0;
    for (int i = 0; i < 256; i++) begin
      b_send(8'(i));
      wait_rx(400);
      check("lb_data", b_rx_data, i);
      check("lb_perr", b_rx_perr, 0);
      check("lb_ferr", b_rx_ferr, 0);
      ack_rx();
      check("lb_valid_clr", b_rx_valid, 0);
    end

    // ---------------- B: injected error frames ----------------
    inj_en = 1'b1;
    inject(8'h3C, 1'b1, 1'b0, 16);
    wait_rx(50);
    check("par_data", b_rx_data, 8'h3C);
    check("par_perr", b_rx_perr, 1);
    check("par_ferr", b_rx_ferr, 0);
    ack_rx();
    check("par_valid_clr", b_rx_valid, 0);

    inject(8'h3C, 1'b0, 1'b1, 16);
    wait_rx(50);
    check("frm_data", b_rx_data, 8'h3C);
    check("frm_perr", b_rx_perr, 0);
    check("frm_ferr", b_rx_ferr, 1);
    ack_rx();

    // ---------------- B: overrun ----------------
    inject(8'h11, 1'b0, 1'b0, 16);
    inject(8'h22, 1'b0, 1'b0, 16);
    check("ovr_valid", b_rx_valid, 1);
    check("ovr_data",  b_rx_data,  8'h11);
    check("ovr_flag",  b_rx_ovr,   1);
    check("ovr_perr",  b_rx_perr,  0);
    ack_rx();
    check("ovr_valid_clr", b_rx_valid, 0);
    check("ovr_flag_clr",  b_rx_ovr,   0);

    // ---------------- B: false start (20 clk low < half of 64-clk bit) ----
    baud_div = 16'd3;
    @(negedge clk);
    inj_line = 1'b0;
    repeat (20) @(negedge clk);
    inj_line = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_no_valid", b_rx_valid, 0);
    inject(8'h96, 1'b0, 1'b0, 64);
    wait_rx(100);
    check("post_glitch_data", b_rx_data, 8'h96);
    check("post_glitch_perr", b_rx_perr, 0);
    ack_rx();

    // ---------------- reset in the middle of a TX frame ----------------
    inj_en = 1'b0;
    b_send(8'h5A);
    repeat (300) @(negedge clk);
    check("mid_frame_busy", b_tx_ready, 0);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_tx",       b_tx,       1);
    check("rst_mid_tx_ready", b_tx_ready, 1);
    check("rst_mid_rx_valid", b_rx_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    b_send(8'hC3);
    wait_rx(1000);
    check("after_rst_data", b_rx_data, 8'hC3);
    check("after_rst_perr", b_rx_perr, 0);
    check("after_rst_ferr", b_rx_ferr, 0);
    ack_rx();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
